// File: rtl/dmem_store_drain_ctrl.sv
// Store-buffer drain sequencer for the data-memory BRAM.
// Buffers committed stores, drains them in order, and forwards them to loads.
module dmem_store_drain_ctrl #(
    parameter int SQ_DEPTH = 4,
    parameter int BRAM_AW  = 16,
    parameter int TAG_W    = 6,
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                store_valid_i,
    input  logic [ADDR_LEN-1:0] store_addr_i,
    input  logic [DATA_LEN-1:0] store_data_i,
    output logic                store_ready_o,
    input  logic                drain_en_i,
    input  logic                load_valid_i,
    input  logic [ADDR_LEN-1:0] load_addr_i,
    input  logic [TAG_W-1:0]    load_tag_i,
    output logic                load_ready_o,
    output logic                resp_valid_o,
    output logic [DATA_LEN-1:0] resp_data_o,
    output logic [TAG_W-1:0]    resp_tag_o,
    input  logic                resp_ready_i,
    output logic                dmem_we_o,
    output logic [BRAM_AW-1:0]  dmem_waddr_o,
    output logic [DATA_LEN-1:0] dmem_wdata_o,
    output logic [BRAM_AW-1:0]  dmem_raddr_o,
    input  logic [DATA_LEN-1:0] dmem_rdata_i
);

    localparam int PW = $clog2(SQ_DEPTH);

    logic [BRAM_AW-1:0]  sq_idx  [SQ_DEPTH];
    logic [DATA_LEN-1:0] sq_data [SQ_DEPTH];
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [PW:0]         count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    logic [BRAM_AW-1:0] load_idx;
    logic [BRAM_AW-1:0] store_idx;
    logic               accept;

    logic                hit;
    logic [DATA_LEN-1:0] hit_data;
    logic [PW-1:0]       slot;

    logic                resp_valid_q;
    logic [TAG_W-1:0]    resp_tag_q;
    logic                fwd_q;
    logic [DATA_LEN-1:0] fwd_data_q;
    logic                hold_q;
    logic [DATA_LEN-1:0] hold_data_q;
    logic [DATA_LEN-1:0] sel_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{load_addr_i[ADDR_LEN-1:BRAM_AW],
                                store_addr_i[ADDR_LEN-1:BRAM_AW]};

    assign full      = (count == (PW+1)'(SQ_DEPTH));
    assign empty     = (count == '0);
    assign store_idx = store_addr_i[BRAM_AW-1:0];
    assign load_idx  = load_addr_i[BRAM_AW-1:0];

    assign store_ready_o = !full;
    assign push          = store_valid_i && store_ready_o;
    // Writes are suppressed in a reset cycle so buffered stores are discarded.
    assign pop           = drain_en_i && !empty && !reset_i;

    assign dmem_we_o    = pop;
    assign dmem_waddr_o = sq_idx[head];
    assign dmem_wdata_o = sq_data[head];
    assign dmem_raddr_o = load_idx;

    assign load_ready_o = !resp_valid_q || resp_ready_i;
    assign accept       = load_valid_i && load_ready_o;

    // Walk oldest to youngest so the last match wins; head is included
    // even when it drains this cycle.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = head;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            slot = head + PW'(k);
            if (((PW+1)'(k) < count) && (sq_idx[slot] == load_idx)) begin
                hit      = 1'b1;
                hit_data = sq_data[slot];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            sq_idx[tail]  <= store_idx;
            sq_data[tail] <= store_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign sel_data     = fwd_q ? fwd_data_q : dmem_rdata_i;
    assign resp_valid_o = resp_valid_q;
    assign resp_tag_o   = resp_tag_q;
    assign resp_data_o  = hold_q ? hold_data_q : sel_data;

    // BRAM data is only valid one cycle, so a stalled result is parked in hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            fwd_q        <= 1'b0;
            fwd_data_q   <= '0;
            hold_q       <= 1'b0;
            hold_data_q  <= '0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_tag_q   <= load_tag_i;
            fwd_q        <= hit;
            fwd_data_q   <= hit_data;
            hold_q       <= 1'b0;
        end else if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            hold_q       <= 1'b0;
        end else if (resp_valid_q && !hold_q) begin
            hold_q      <= 1'b1;
            hold_data_q <= sel_data;
        end
    end

endmodule

// File: tb/tb_dmem_store_drain_ctrl.sv
// Scoreboard bench for dmem_store_drain_ctrl with a BRAM model and a
// program-order memory reference.
module tb_dmem_store_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        store_valid;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        store_ready;
    logic        drain_en;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [5:0]  load_tag;
    logic        load_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [5:0]  resp_tag;
    logic        resp_ready;
    logic        dmem_we;
    logic [15:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [15:0] dmem_raddr;
    logic [31:0] dmem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_store_drain_ctrl dut (
        .clk_i(clk), .reset_i(reset_i),
        .store_valid_i(store_valid), .store_addr_i(store_addr),
        .store_data_i(store_data), .store_ready_o(store_ready),
        .drain_en_i(drain_en),
        .load_valid_i(load_valid), .load_addr_i(load_addr),
        .load_tag_i(load_tag), .load_ready_o(load_ready),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .resp_tag_o(resp_tag), .resp_ready_i(resp_ready),
        .dmem_we_o(dmem_we), .dmem_waddr_o(dmem_waddr),
        .dmem_wdata_o(dmem_wdata), .dmem_raddr_o(dmem_raddr),
        .dmem_rdata_i(dmem_rdata)
    );

    function automatic logic [31:0] init_val(logic [15:0] idx);
        return {16'hC0DE, idx};
    endfunction

    // BRAM: read-old on collision, 1-cycle read latency.
    logic [31:0] bram [logic [15:0]];
    always @(posedge clk) begin
        logic [31:0] r;
        r = bram.exists(dmem_raddr) ? bram[dmem_raddr] : init_val(dmem_raddr);
        if (dmem_we) bram[dmem_waddr] = dmem_wdata;
        dmem_rdata <= r;
    end

    // Reference: memory as seen in program order, every accepted store
    // applied immediately; plus the queue of stores owed to the BRAM.
    typedef struct { logic [15:0] idx; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] data; logic [5:0] tag; } rsp_t;
    logic [31:0] ref_mem [logic [15:0]];
    wr_t  pend[$];
    rsp_t exp_q[$];

    function automatic logic [31:0] ref_rd(logic [15:0] idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [5:0]  prev_tag;

    always @(negedge clk) begin
        if (reset_i) begin
            pend.delete();
            exp_q.delete();
            ref_mem = bram;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", resp_valid, 1'b1);
                chk("stall_data", resp_data, prev_data);
                chk("stall_tag", resp_tag, prev_tag);
            end
            chk("store_ready", store_ready, pend.size() < 4);
            chk("load_ready", load_ready, !resp_valid || resp_ready);
            chk("we", dmem_we, drain_en && pend.size() > 0);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1'b1, 1'b0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_tag", resp_tag, e.tag);
                end
            end
            if (dmem_we && pend.size() > 0) begin
                wr_t w;
                w = pend.pop_front();
                chk("waddr", dmem_waddr, w.idx);
                chk("wdata", dmem_wdata, w.data);
            end
            if (load_valid && load_ready) begin
                rsp_t e;
                e.data = ref_rd(load_addr[15:0]);
                e.tag  = load_tag;
                exp_q.push_back(e);
            end
            if (store_valid && store_ready) begin
                wr_t w;
                w.idx  = store_addr[15:0];
                w.data = store_data;
                pend.push_back(w);
                ref_mem[w.idx] = store_data;
            end
            prev_stall = resp_valid && !resp_ready;
            prev_data  = resp_data;
            prev_tag   = resp_tag;
        end
    end

    task automatic step(input logic sv, input logic [31:0] sa,
                        input logic [31:0] sd, input logic de,
                        input logic lv, input logic [31:0] la,
                        input logic [5:0] lt, input logic rr);
        store_valid = sv;
        store_addr  = sa;
        store_data  = sd;
        drain_en    = de;
        load_valid  = lv;
        load_addr   = la;
        load_tag    = lt;
        resp_ready  = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic de, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, de, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle(0, 2);
        reset_i = 1'b0;
        drain_en = 1'b1;
        #1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_store_ready", store_ready, 1'b1);
        chk("rst_load_ready", load_ready, 1'b1);
    endtask

    initial begin
        reset_i = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();

        // single store drains the next cycle
        step(1, 32'h0000_0010, 32'hDEADBEEF, 1, 0, 0, 0, 1);
        chk("first_we", dmem_we, 1'b1);
        chk("first_waddr", dmem_waddr, 16'h0010);
        chk("first_wdata", dmem_wdata, 32'hDEADBEEF);
        idle(1, 1);
        chk("first_empty_we", dmem_we, 1'b0);

        // overfill with drain off, then drain in order with wrap
        for (int i = 0; i < 5; i++)
            step(1, 32'h100 + i, 32'h5000 + i, 0, 0, 0, 0, 1);
        chk("full_ready", store_ready, 1'b0);
        idle(1, 6);

        // youngest of two buffered stores forwards
        step(1, 32'h20, 1, 0, 0, 0, 0, 1);
        step(1, 32'h20, 2, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h20, 5, 1);
        idle(1, 4);

        // load hits the head while it drains, then reads the BRAM copy
        step(1, 32'h30, 32'hAA, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 32'h30, 1, 1);
        step(0, 0, 0, 1, 1, 32'h30, 2, 1);
        idle(1, 2);

        // same-cycle store is younger than the load
        step(1, 32'h40, 3, 1, 0, 0, 0, 1);
        idle(1, 2);
        step(1, 32'h40, 7, 0, 1, 32'h40, 9, 1);
        idle(1, 3);
        step(0, 0, 0, 1, 1, 32'hFFFF_0040, 10, 1);
        idle(1, 2);

        // response stall, then 1 result per cycle
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 1, 32'h10 + 32'(i), 6'(20 + i), 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 1, 32'h20 + 32'(i), 6'(30 + i), 1);
        idle(1, 2);

        // reset with buffered stores and a load in flight
        step(1, 32'h50, 32'h1111, 0, 0, 0, 0, 1);
        step(1, 32'h51, 32'h2222, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h50, 3, 0);
        do_reset();
        step(0, 0, 0, 1, 1, 32'h50, 4, 1);
        idle(1, 2);

        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 1) == 1,
                 {$urandom_range(0, 65535), 16'($urandom_range(0, 7))},
                 $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 {$urandom_range(0, 65535), 16'($urandom_range(0, 7))},
                 6'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
        end

        begin
            int n;
            n = 0;
            while ((pend.size() != 0 || exp_q.size() != 0) && n < 50) begin
                idle(1, 1);
                n++;
            end
            chk("drain_timeout", (pend.size() == 0) && (exp_q.size() == 0), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_store_drain_ctrl.md
Name: dmem_store_drain_ctrl

Overview:
- Sequences the dual-port data-memory BRAM (one write port, one read port, 1-cycle synchronous read).
- Buffers committed stores in a FIFO and drains them to the write port one per cycle.
- Serves load requests through the read port and forwards data from stores still buffered, so loads never see stale or colliding BRAM data.
- Returns each load result with its tag through a valid/ready response interface.

Parameters:
- SQ_DEPTH, 4, store-FIFO entries (power of two, ≥2).
- BRAM_AW, 16, BRAM word-index width; index = address[BRAM_AW-1:0].
- TAG_W, 6, load tag width.
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- store_valid_i  in  1  committed store offered.
- store_addr_i  in  ADDR_LEN  store address.
- store_data_i  in  DATA_LEN  store data.
- store_ready_o  out  1  FIFO can accept a store.
- drain_en_i  in  1  permits draining to BRAM this cycle.
- load_valid_i  in  1  load request.
- load_addr_i  in  ADDR_LEN  load address.
- load_tag_i  in  TAG_W  load tag.
- load_ready_o  out  1  load accepted this cycle if valid.
- resp_valid_o  out  1  load result valid.
- resp_data_o  out  DATA_LEN  load result.
- resp_tag_o  out  TAG_W  load tag.
- resp_ready_i  in  1  consumer takes result.
- dmem_we_o  out  1  BRAM write enable.
- dmem_waddr_o  out  BRAM_AW  BRAM write index.
- dmem_wdata_o  out  DATA_LEN  BRAM write data.
- dmem_raddr_o  out  BRAM_AW  BRAM read index.
- dmem_rdata_i  in  DATA_LEN  BRAM read data, valid 1 cycle after dmem_raddr_o.

Behaviour:
- Interface: one clock (clk_i); reset (reset_i) is synchronous and active-high.
- Reset: FIFO empty; resp_valid_o=0; dmem_we_o=0; hold register invalid; store_ready_o=1; load_ready_o=1 from the first cycle after reset.
- Reset mid-operation: buffered stores and the in-flight load are discarded, not written.
- Store FIFO:
  - Circular buffer with wrap-around head/tail pointers and an occupancy counter of log2(SQ_DEPTH)+1 bits.
  - store_ready_o = !full, registered-state only; it does not depend on a drain in the same cycle.
  - Push on store_valid_i && store_ready_o.
- Drain:
  - When drain_en_i && !empty, dmem_we_o=1 combinationally, with waddr/wdata taken from the head entry; head pops at the clock edge.
  - Otherwise dmem_we_o=0.
  - Push and pop in the same cycle leave occupancy unchanged.
- Load issue:
  - load_ready_o = !resp_valid_o || resp_ready_i.
  - dmem_raddr_o = load_addr_i index, driven combinationally.
  - On accept (cycle N): CAM-compare the index against all valid FIFO entries, including the head draining in cycle N.
  - On a hit, register the youngest matching entry's data and set fwd flag.
  - A store pushed in cycle N is NOT visible to a load accepted in cycle N, because the load is ordered older.
- Load response:
  - resp_valid_o=1 in cycle N+1 with registered tag; resp_data_o = forwarded data if fwd, else dmem_rdata_i.
  - If resp_ready_i=0 in N+1, capture the selected data into the hold register; resp_data_o comes from hold until accepted.
  - Throughput is 1 load/cycle when resp_ready_i stays high.
- Collision rule: the BRAM read-during-write result is never used for the same index; forwarding covers every such case.
- Address compare uses the BRAM_AW index bits only, consistent with BRAM aliasing.

Test Plan:
- Reset, then push store A=0x10/0xDEADBEEF with drain_en_i=1 → dmem_we_o=1, waddr=0x10, wdata=0xDEADBEEF the next cycle; FIFO empty after.
- drain_en_i=0, push SQ_DEPTH+1 stores → store_ready_o=0 after the 4th; 5th held. Then enable drain → 4 writes in push order on consecutive cycles; pointer wrap verified.
- drain_en_i=0, stores 0x20←1 then 0x20←2, load 0x20 tag 5 → resp next cycle, data=2, tag=5.
- Load 0x30 in the same cycle that head store 0x30←0xAA drains → resp data 0xAA; a load 0x30 issued 1 cycle later gets 0xAA from BRAM.
- Same-cycle push 0x40←7 and load 0x40 (BRAM holds 3) → resp data 3.
- Loads back-to-back with resp_ready_i=0 for 3 cycles → resp_valid_o held; data/tag stable; load_ready_o=0; no loss. Release → 1 resp/cycle.
